ms8_feeder: RTL and testbench

//  Upstream master stage for the TestMasterSlave8 slave port. Accepts integers over a

---
 rtl/testmasterslave8_types.sv | 18 +
 rtl/ms8_fifo.sv | 69 ++++++
 rtl/ms8_feeder.sv | 110 +++++++++++
 tb/tb_ms8_feeder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/testmasterslave8_types.sv
`default_nettype none
// ============================================================================
// Module      : testmasterslave8_types (package)
// Description : Shared types and constants for the TestMasterSlave8 feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package testmasterslave8_types;

    localparam int FEEDER_DEPTH_DEFAULT = 4;
    localparam int FEEDER_DATA_W        = 32;

    typedef enum logic [0:0] {
        section_idle = 1'b0,
        section_hold = 1'b1
    } FeederSections;

endpackage
`default_nettype wire

// File: rtl/ms8_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ms8_fifo
// Description : Small power-of-two FIFO with push/pop/flush, exposing the
//               head entry, the current occupancy and next-edge occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module ms8_fifo
    import testmasterslave8_types::*;
#(
    parameter int DEPTH = FEEDER_DEPTH_DEFAULT,
    parameter int WIDTH = FEEDER_DATA_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;

    // Flush dominates; otherwise simultaneous push and pop leave count unchanged.
    assign w_count_next = flush ? '0 : (r_count + CW'(push) - CW'(pop));

    // Storage write; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    assign head       = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign count_next = w_count_next;

endmodule
`default_nettype wire

// File: rtl/ms8_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ms8_feeder
// Description : Master-side feeder for the TestMasterSlave8 slave port.
//               Buffers producer integers, adds a constant offset and emits
//               each one with a single-cycle sync strobe and minimum gap.
// Revision    : 1.0 - initial release
// ============================================================================
module ms8_feeder
    import testmasterslave8_types::*;
#(
    parameter int                 DEPTH     = FEEDER_DEPTH_DEFAULT,
    parameter int                 GAP       = 1,
    parameter logic signed [31:0] ADD_CONST = 32'sd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] m_in,
    input  logic               m_in_sync,
    output logic               m_in_notify,
    input  logic               flush,
    output logic signed [31:0] s_out,
    output logic               s_out_sync
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [3:0]    C_GAP   = 4'(GAP);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic                w_push;
    logic                w_pop;
    logic [31:0]         w_head;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_count_next;

    FeederSections       r_section;
    logic [3:0]          r_gap_cnt;
    logic signed [31:0]  r_s_out;
    logic                r_s_out_sync;
    logic                r_notify;

    // A transfer only happens when the feeder has advertised room.
    assign w_push = m_in_sync && r_notify;
    // Popping is only possible from idle with data already stored, so a value
    // pushed into an empty FIFO is never emitted on its own push edge.
    assign w_pop  = (r_section == section_idle) && (w_count != '0);

    ms8_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (flush),
        .din        (m_in),
        .head       (w_head),
        .count      (w_count),
        .count_next (w_count_next)
    );

    // Emission FSM with gap counter, output registers and notify register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_section    <= section_idle;
            r_gap_cnt    <= '0;
            r_s_out      <= '0;
            r_s_out_sync <= 1'b0;
            r_notify     <= 1'b0;
        end else if (flush) begin
            r_section    <= section_idle;
            r_gap_cnt    <= '0;
            r_s_out_sync <= 1'b0;
            r_notify     <= 1'b1;
        end else begin
            r_notify <= (w_count_next < C_DEPTH);
            case (r_section)
                section_idle: begin
                    if (w_pop) begin
                        r_s_out      <= $signed(w_head) + ADD_CONST;
                        r_s_out_sync <= 1'b1;
                        r_gap_cnt    <= C_GAP;
                        r_section    <= section_hold;
                    end else begin
                        r_s_out_sync <= 1'b0;
                    end
                end
                section_hold: begin
                    r_s_out_sync <= 1'b0;
                    if (r_gap_cnt == '0) begin
                        r_section <= section_idle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_section    <= section_idle;
                    r_s_out_sync <= 1'b0;
                end
            endcase
        end
    end

    assign m_in_notify = r_notify;
    assign s_out       = r_s_out;
    assign s_out_sync  = r_s_out_sync;

endmodule
`default_nettype wire

// File: tb/tb_ms8_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ms8_feeder
// Description : Directed self-checking bench for ms8_feeder. Three instances
//               with different GAP/ADD_CONST share clock, reset and producer
//               inputs; each scenario observes the instance it targets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ms8_feeder;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] m_in = '0;
    logic               m_in_sync = 1'b0;
    logic               flush = 1'b0;

    logic               notify_a, notify_b, notify_c;
    logic signed [31:0] s_out_a, s_out_b, s_out_c;
    logic               sync_a, sync_b, sync_c;

    int total = 0;
    int bad   = 0;

    ms8_feeder #(.DEPTH(4), .GAP(1), .ADD_CONST(32'sd5)) u_a (
        .clk(clk), .rst(rst), .m_in(m_in), .m_in_sync(m_in_sync),
        .m_in_notify(notify_a), .flush(flush), .s_out(s_out_a), .s_out_sync(sync_a)
    );
    ms8_feeder #(.DEPTH(4), .GAP(15), .ADD_CONST(32'sd0)) u_b (
        .clk(clk), .rst(rst), .m_in(m_in), .m_in_sync(m_in_sync),
        .m_in_notify(notify_b), .flush(flush), .s_out(s_out_b), .s_out_sync(sync_b)
    );
    ms8_feeder #(.DEPTH(4), .GAP(0), .ADD_CONST(32'sd1)) u_c (
        .clk(clk), .rst(rst), .m_in(m_in), .m_in_sync(m_in_sync),
        .m_in_notify(notify_c), .flush(flush), .s_out(s_out_c), .s_out_sync(sync_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_all();
        m_in_sync = 1'b0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
    endtask

    function automatic logic signed [31:0] val(input int k);
        return 32'(k * 7 - 50);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;
        int got;
        int sent;
        int last;
        int saw_low;
        logic will_push;
        logic [31:0] q[$];
        logic [31:0] exp_v;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) tick();
        check("rst_s_out",  s_out_a, 0);
        check("rst_sync",   32'(sync_a), 0);
        check("rst_notify", 32'(notify_a), 0);
        rst = 1'b0;
        check("notify_before_edge", 32'(notify_b), 0);
        tick();
        check("notify_after_release", 32'(notify_a), 1);

        // ---------------- single value, GAP=1, ADD_CONST=5 ----------------
        m_in = 32'sd10; m_in_sync = 1'b1;
        tick();                                      // E: push 10
        check("single_no_same_edge", 32'(sync_a), 0);
        m_in = 32'sd20;
        tick();                                      // E+1: emit 15, push 20
        m_in_sync = 1'b0;
        check("single_s_out", s_out_a, 15);
        check("single_sync",  32'(sync_a), 1);
        tick();                                      // E+2
        check("single_pulse_width", 32'(sync_a), 0);
        check("single_hold_value",  s_out_a, 15);
        tick();                                      // E+3
        check("single_gap_e3", 32'(sync_a), 0);
        tick();                                      // E+4: next value may emit
        check("second_sync",  32'(sync_a), 1);
        check("second_s_out", s_out_a, 25);
        flush_all();

        // ---------------- fill, GAP=15 ----------------
        m_in = 32'sd0; m_in_sync = 1'b1;
        tick();                                      // E0: push stall value
        m_in = 32'sd1;
        tick();                                      // E1: emit 0, push 1
        check("fill_stall_pulse", 32'(sync_b), 1);
        check("fill_stall_value", s_out_b, 0);
        m_in = 32'sd2;
        tick();                                      // E2
        m_in = 32'sd3;
        tick();                                      // E3: count 3
        check("fill_notify_3", 32'(notify_b), 1);
        m_in = 32'sd4;
        tick();                                      // E4: count 4
        m_in_sync = 1'b0;
        check("fill_notify_full", 32'(notify_b), 0);
        pulses = 0;
        for (int c = 5; c <= 80; c++) begin
            tick();
            if (sync_b) begin
                pulses++;
                check("fill_order", s_out_b, 32'(pulses));
                check("fill_spacing", 32'(c), 32'(1 + 17 * pulses));
            end
        end
        check("fill_pulse_count", 32'(pulses), 4);
        flush_all();

        // ---------------- flush mid-stream on B ----------------
        m_in = 32'sd100; m_in_sync = 1'b1;
        tick();                                      // F0
        m_in = 32'sd101;
        tick();                                      // F1: emit 100
        check("flush_first_pulse", s_out_b, 100);
        m_in = 32'sd102;
        tick();                                      // F2
        m_in = 32'sd103;
        tick();                                      // F3: 3 queued
        m_in_sync = 1'b0;
        repeat (14) tick();                          // F17
        check("flush_pre_sync", 32'(sync_b), 0);
        flush = 1'b1;
        tick();                                      // F18: pop edge, flushed
        flush = 1'b0;
        check("flush_no_pulse", 32'(sync_b), 0);
        check("flush_s_out_held", s_out_b, 100);
        check("flush_notify", 32'(notify_b), 1);
        pulses = 0;
        repeat (40) begin
            tick();
            if (sync_b) pulses++;
        end
        check("flush_fifo_empty", 32'(pulses), 0);

        // ---------------- wrap, ADD_CONST=1 ----------------
        flush_all();
        m_in = 32'sh7FFFFFFF; m_in_sync = 1'b1;
        tick();
        m_in_sync = 1'b0;
        tick();
        check("wrap_s_out", s_out_c, 32'h80000000);
        check("wrap_sync",  32'(sync_c), 1);
        tick();
        flush_all();

        // ---------------- concurrent push every cycle, GAP=0 ----------------
        q.delete();
        sent = 0; got = 0; last = -1; saw_low = 0; cyc = 0;
        m_in = val(0); m_in_sync = 1'b1;
        while (got < 100 && cyc < 1000) begin
            will_push = m_in_sync && notify_c;
            tick();
            cyc++;
            if (will_push) begin
                q.push_back(m_in + 32'sd1);
                sent++;
                if (sent < 100) m_in = val(sent);
                else            m_in_sync = 1'b0;
            end
            if (sync_c) begin
                if (q.size() == 0) begin
                    check("conc_unexpected_pulse", s_out_c, 32'hDEAD_BEEF);
                end else begin
                    exp_v = q.pop_front();
                    check("conc_value", s_out_c, exp_v);
                end
                if (last >= 0) check("conc_interval", 32'(cyc - last), 2);
                last = cyc;
                got++;
            end
            if (!notify_c) saw_low++;
        end
        m_in_sync = 1'b0;
        check("conc_received", 32'(got), 100);
        check("conc_notify_toggled", 32'(saw_low > 0), 1);
        flush_all();

        // ---------------- asynchronous reset mid-burst ----------------
        m_in = 32'sd5; m_in_sync = 1'b1;
        repeat (3) tick();
        m_in_sync = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_s_out",  s_out_c, 0);
        check("async_rst_sync",   32'(sync_c), 0);
        check("async_rst_notify", 32'(notify_c), 0);
        tick();
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            tick();
            if (sync_c) pulses++;
        end
        check("async_rst_lost", 32'(pulses), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
